// File: rtl/online_serial_adder.sv
// Online (MSD-first) adder for borrow-save operands with an online delay of 2.
// Digit-serial result on a valid/ready output, plus a parallel copy of each full result.
module online_serial_adder #(
    parameter int DIGITS = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              x_plus,
    input  logic              x_minus,
    input  logic              y_plus,
    input  logic              y_minus,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_plus,
    output logic              out_minus,
    output logic              out_last,
    output logic [DIGITS:0]   z_plus,
    output logic [DIGITS:0]   z_minus,
    output logic              done
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH1, FLUSH2} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            slot_free, accept, step, emit;

    logic [1:0]        cx_p0, cy_p0;
    logic [1:0]        hx_p1, hy_p1, hx_p2, hy_p2;
    logic signed [2:0] sum_p1, sum_p2;
    logic signed [1:0] t_p1, w_p2;
    logic signed [2:0] s_p0;
    logic              s_plus, s_minus;
    logic [DIGITS-1:0] sh_plus, sh_minus;

    function automatic logic signed [1:0] dig_val(input logic [1:0] d);
        return $signed({1'b0, d[1]}) - $signed({1'b0, d[0]});
    endfunction

    function automatic logic nonneg(input logic [1:0] d);
        return !(!d[1] && d[0]);
    endfunction

    function automatic logic signed [2:0] pair_sum(input logic [1:0] a, input logic [1:0] b);
        logic signed [1:0] va;
        logic signed [1:0] vb;
        va = dig_val(a);
        vb = dig_val(b);
        return {va[1], va} + {vb[1], vb};
    endfunction

    // Transfer part of the recoding; odd sums look one digit ahead.
    function automatic logic signed [1:0] rec_t(input logic signed [2:0] p, input logic nn);
        case (p)
            3'b010:  rec_t = 2'b01;
            3'b110:  rec_t = 2'b11;
            3'b001:  rec_t = nn ? 2'b01 : 2'b00;
            3'b111:  rec_t = nn ? 2'b00 : 2'b11;
            default: rec_t = 2'b00;
        endcase
    endfunction

    function automatic logic signed [1:0] rec_w(input logic signed [2:0] p, input logic nn);
        case (p)
            3'b001, 3'b111: rec_w = nn ? 2'b11 : 2'b01;
            default:        rec_w = 2'b00;
        endcase
    endfunction

    always_comb begin
        slot_free = !out_valid || out_ready;
        in_ready  = slot_free && (state == IDLE || state == RUN);
        accept    = in_valid && in_ready;
        step      = slot_free && (accept || state == FLUSH1 || state == FLUSH2);
        emit      = step && (state != IDLE);
        state_nx  = state;
        cnt_nx    = cnt;
        case (state)
            IDLE, RUN: begin
                if (accept) begin
                    cnt_nx   = (state == IDLE) ? CW'(1) : cnt + CW'(1);
                    state_nx = (cnt_nx == LAST_CNT) ? FLUSH1 : RUN;
                end
            end
            FLUSH1: if (step) state_nx = FLUSH2;
            FLUSH2: begin
                if (step) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p0: incoming digit pair (zero while flushing)
    always_comb begin
        cx_p0 = (state == FLUSH1 || state == FLUSH2) ? 2'b00 : {x_plus, x_minus};
        cy_p0 = (state == FLUSH1 || state == FLUSH2) ? 2'b00 : {y_plus, y_minus};
    end

    // Stage p1/p2: s_{j-2} = w_{j-2} + t_{j-1} from the two history pairs
    always_comb begin
        sum_p1  = pair_sum(hx_p1, hy_p1);
        sum_p2  = pair_sum(hx_p2, hy_p2);
        t_p1    = rec_t(sum_p1, nonneg(cx_p0) && nonneg(cy_p0));
        w_p2    = rec_w(sum_p2, nonneg(hx_p1) && nonneg(hy_p1));
        s_p0    = {w_p2[1], w_p2} + {t_p1[1], t_p1};
        s_plus  = (s_p0 == 3'b001);
        s_minus = (s_p0 == 3'b111);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hx_p1     <= '0;
            hy_p1     <= '0;
            hx_p2     <= '0;
            hy_p2     <= '0;
            out_valid <= 1'b0;
            out_plus  <= 1'b0;
            out_minus <= 1'b0;
            out_last  <= 1'b0;
            z_plus    <= '0;
            z_minus   <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            done  <= step && (state == FLUSH2);
            if (step) begin
                hx_p1 <= cx_p0;
                hy_p1 <= cy_p0;
                hx_p2 <= (state == IDLE) ? 2'b00 : hx_p1;
                hy_p2 <= (state == IDLE) ? 2'b00 : hy_p1;
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_plus  <= s_plus;
                out_minus <= s_minus;
                out_last  <= (state == FLUSH2);
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_plus  <= 1'b0;
                out_minus <= 1'b0;
                out_last  <= 1'b0;
            end
            if (emit && state == FLUSH2) begin
                z_plus  <= {sh_plus, s_plus};
                z_minus <= {sh_minus, s_minus};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (emit) begin
            sh_plus  <= {sh_plus[DIGITS-2:0], s_plus};
            sh_minus <= {sh_minus[DIGITS-2:0], s_minus};
        end
    end

endmodule

// File: doc/online_serial_adder.md
ONLINE_SERIAL_ADDER -- requirements
Module: online_serial_adder

Interface
REQ-001 The block SHALL have one parameter, DIGITS, default 6, giving the operand length in signed digits; legal values are 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an input digit pair is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts the input digit pair this cycle.
REQ-006 The block SHALL have ports x_plus, x_minus, y_plus and y_minus, inputs, 1 bit each: borrow-save digits, MSD first.
REQ-007 Each borrow-save digit's value SHALL be plus minus minus; (1,1) is a legal zero.
REQ-008 The block SHALL have port out_valid, output, 1 bit: an output digit is held.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the output digit.
REQ-010 The block SHALL have ports out_plus and out_minus, outputs, 1 bit each: the result digit, MSD first.
REQ-011 The block SHALL have port out_last, output, 1 bit: the held output digit is s_DIGITS.
REQ-012 The block SHALL have ports z_plus and z_minus, outputs, DIGITS+1 bits each: the parallel result; bit DIGITS holds s_0 and bit 0 holds s_DIGITS.
REQ-013 The block SHALL have port done, output, 1 bit: a one-cycle pulse when z_plus/z_minus update.

Function
REQ-014 The block SHALL add X = sum x_j*2^-j and Y = sum y_j*2^-j over j=1..DIGITS, emitting DIGITS+1 digits s_0..s_DIGITS with sum over k of s_k*2^-k equal to X+Y, and each s_k in {-1,0,1}.
REQ-015 Output digit encoding SHALL be +1=(1,0), -1=(0,1), 0=(0,0); (1,1) SHALL never be driven.
REQ-016 The block SHALL compute p_j = x_j + y_j, and "next-nonneg" SHALL mean that x_{j+1} and y_{j+1} are both non-negative.
REQ-017 Recoding of p_j into (t_j, w_j) SHALL be:
- p_j = 2: (1, 0)
- p_j = -2: (-1, 0)
- p_j = 0: (0, 0)
- p_j = 1: (1, -1) if next-nonneg, else (0, 1)
- p_j = -1: (0, -1) if next-nonneg, else (-1, 1)
REQ-018 The block SHALL form s_k = w_k + t_{k+1}, with p_0 = 0 (so w_0 = 0) and with p_j = 0 for j > DIGITS.
REQ-019 A step SHALL fire when the output slot is free (!out_valid || out_ready) AND either an input is accepted or the state is FLUSH1/FLUSH2.
REQ-020 in_ready SHALL equal slot-free AND state in {IDLE, RUN}; an input is accepted when in_valid && in_ready.
REQ-021 Step j (j=1..DIGITS+2) SHALL use p_j; flush steps (j = DIGITS+1, DIGITS+2) SHALL use zero digits.
REQ-022 Step 1 SHALL emit nothing; step j >= 2 SHALL load s_{j-2} into the output register, with out_valid=1 from the next cycle; the online delay is 2.
REQ-023 The block SHALL keep two digit-pair history registers, cleared at step 1 of every operand.
REQ-024 State transitions SHALL be:
- IDLE: first accept -> RUN, or -> FLUSH1 if DIGITS was already reached
- RUN: the DIGITS-th accept -> FLUSH1
- FLUSH1: step -> FLUSH2
- FLUSH2: step -> IDLE
REQ-025 A digit counter SHALL count accepts, 0..DIGITS.
REQ-026 When out_valid && !out_ready (stall), all state, history and output SHALL hold, and in_ready SHALL be 0.
REQ-027 out_valid SHALL drop after a transfer unless a step reloads the output in the same cycle.
REQ-028 out_last SHALL be 1 exactly while s_DIGITS is held.
REQ-029 Each emitted digit SHALL shift into an internal result shift register.
REQ-030 When s_DIGITS is loaded, z_plus/z_minus SHALL update to the full result and done SHALL pulse for the first cycle in which out_last=1; z SHALL hold until the next done.
REQ-031 The first digit of the next operand MAY be accepted in IDLE while s_DIGITS is still held, provided the slot is free that cycle (back-to-back operands, no bubble).
REQ-032 With continuous valid/ready and first accept in cycle c, s_0 SHALL be visible in cycle c+2, and s_DIGITS plus done in cycle c+DIGITS+2.

Reset
REQ-033 When rst_n=0 at a clock edge, the next state SHALL be IDLE, with counter=0, history=0, out_valid=0, out_plus=out_minus=0, out_last=0, z_plus=z_minus=0 and done=0.
REQ-034 Reset mid-operation SHALL abort the operand: no further digits and no done for it, and in_ready SHALL be 1 in the first cycle after rst_n returns to 1.

Verification
REQ-035 The bench SHALL cover: DIGITS=6, x=y=(1,0,1,0,1,0), continuous handshake -> out digits +1,0,+1,0,+1,0,0 (value 1.3125), out_last on the 7th, done with z_plus=1010100b, z_minus=0.
REQ-036 The bench SHALL cover: x=y=all -1 -> -1,-1,-1,-1,-1,-1,0 (value -63/32), z_minus=1111110b.
REQ-037 The bench SHALL cover: x=(1,0,0,0,0,0), y=(0,-1,0,0,0,0), exercising the lookahead -> 0,+1,-1,0,0,0,0 (value 1/4).
REQ-038 The bench SHALL cover: out_ready=0 for 5 cycles at s_2 -> in_ready=0 and out digits held stable, then the sequence resumes unchanged.
REQ-039 The bench SHALL cover: rst_n=0 after 3 accepts -> out_valid=0 next cycle, no done, and a following operand gives the correct result.
REQ-040 The bench SHALL cover: two back-to-back operands, the first with (1,1) inputs -> no idle cycle between them, and both results correct.
